// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that lets NUM_REQ bursty producers share one FIFO write port.
// Grants are burst-length limited, throttled by half-full, and released on a stalled owner.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MAX_BURST   = 4,
    parameter int unsigned STALL_LIMIT = 8,
    parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_halffull,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    localparam int unsigned BCW = $clog2(MAX_BURST) + 1;
    localparam int unsigned SCW = $clog2(STALL_LIMIT) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] last_id_q, last_id_d;
    logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [SCW-1:0]  stall_cnt_q, stall_cnt_d;

    logic            rr_found;
    logic [ID_W-1:0] rr_winner;
    logic            accept;
    logic [BCW-1:0]  beat_inc;
    logic [BCW-1:0]  beat_limit;
    logic [DATA_WIDTH-1:0] beats [NUM_REQ];

    // Unpack the flat data bus into one beat per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign beats[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search starting just after the previous owner.
    always_comb begin
        int unsigned idx;
        rr_found  = 1'b0;
        rr_winner = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_id_q) + k) % NUM_REQ;
            if (!rr_found && req_valid[ID_W'(idx)]) begin
                rr_found  = 1'b1;
                rr_winner = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            last_id_q   <= ID_W'(NUM_REQ - 1);
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            last_id_q   <= last_id_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state and write-port control; the write path is combinational for zero latency.
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        last_id_d   = last_id_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        req_ready   = '0;
        w_en        = 1'b0;
        data_in     = '0;
        accept      = 1'b0;
        beat_inc    = beat_cnt_q + BCW'(1);
        beat_limit  = fifo_halffull ? BCW'(1) : BCW'(MAX_BURST);

        unique case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_id_d  = rr_winner;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                req_ready[grant_id_q] = !fifo_full;
                accept                = req_valid[grant_id_q] && !fifo_full;
                w_en                  = accept;
                data_in               = beats[grant_id_q];
                if (accept) begin
                    beat_cnt_d  = beat_inc;
                    stall_cnt_d = '0;
                    if (req_last[grant_id_q] || (beat_inc == beat_limit)) begin
                        state_d   = IDLE;
                        last_id_d = grant_id_q;
                    end
                end else if (!fifo_full) begin
                    // Only an idle owner counts towards release; backpressure holds the count.
                    if (stall_cnt_q == SCW'(STALL_LIMIT - 1)) begin
                        state_d   = IDLE;
                        last_id_d = grant_id_q;
                    end else begin
                        stall_cnt_d = stall_cnt_q + SCW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_id = grant_id_q;
    assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_halffull;
    logic        w_en;
    logic [7:0]  data_in;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       f;
        logic       h;
        logic       ew;
        logic [3:0] er;
        logic       eb;
        logic [1:0] eg;
    } vec_t;

    vec_t tbl[$];

    fifo_wr_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .STALL_LIMIT(8)
    ) dut (
        .wclk(wclk), .wrst(wrst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_halffull(fifo_halffull),
        .w_en(w_en), .data_in(data_in), .grant_id(grant_id), .busy(busy)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input logic [1:0] i);
        return req_data[{i, 3'b000} +: 8];
    endfunction

    // One cycle: inputs already driven; sample at the falling edge, then move past the next rising edge.
    task automatic cyc(input string nm, input logic ew, input logic [3:0] er,
                       input logic eb, input logic [1:0] eg);
        @(negedge wclk);
        chk({nm, ".w_en"},  32'(w_en),      32'(ew));
        chk({nm, ".ready"}, 32'(req_ready), 32'(er));
        chk({nm, ".busy"},  32'(busy),      32'(eb));
        chk({nm, ".gid"},   32'(grant_id),  32'(eg));
        if (ew) chk({nm, ".data"}, 32'(data_in), 32'(exp_data(eg)));
        @(posedge wclk);
        #1;
    endtask

    task automatic idle_outputs(input string nm);
        @(negedge wclk);
        chk({nm, ".w_en"},  32'(w_en),      32'd0);
        chk({nm, ".ready"}, 32'(req_ready), 32'd0);
        chk({nm, ".busy"},  32'(busy),      32'd0);
        chk({nm, ".data"},  32'(data_in),   32'd0);
        chk({nm, ".gid"},   32'(grant_id),  32'd0);
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst          = 1'b1;
        req_valid     = '0;
        req_last      = '0;
        fifo_full     = 1'b0;
        fifo_halffull = 1'b0;
        req_data      = 32'hA3A2A1A0;
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        idle_outputs("reset");
    endtask

    task automatic add(input logic [3:0] v, input logic [3:0] l, input logic f, input logic h,
                       input logic ew, input logic [3:0] er, input logic eb, input logic [1:0] eg);
        vec_t r;
        r.v = v; r.l = l; r.f = f; r.h = h; r.ew = ew; r.er = er; r.eb = eb; r.eg = eg;
        tbl.push_back(r);
    endtask

    initial begin
        // Round-robin single-beat grants 0,1,2,3,0 with a bubble between each.
        add(4'hF, 4'hF, 0, 0, 0, 4'h0, 0, 2'd0);
        add(4'hF, 4'hF, 0, 0, 1, 4'h1, 1, 2'd0);
        add(4'hF, 4'hF, 0, 0, 0, 4'h0, 0, 2'd0);
        add(4'hF, 4'hF, 0, 0, 1, 4'h2, 1, 2'd1);
        add(4'hF, 4'hF, 0, 0, 0, 4'h0, 0, 2'd1);
        add(4'hF, 4'hF, 0, 0, 1, 4'h4, 1, 2'd2);
        add(4'hF, 4'hF, 0, 0, 0, 4'h0, 0, 2'd2);
        add(4'hF, 4'hF, 0, 0, 1, 4'h8, 1, 2'd3);
        add(4'hF, 4'hF, 0, 0, 0, 4'h0, 0, 2'd3);
        add(4'hF, 4'hF, 0, 0, 1, 4'h1, 1, 2'd0);
        // Requester 2 alone, no last: 4 beats, bubble, re-grant, 2 beats, then stalls out.
        add(4'h4, 4'h0, 0, 0, 0, 4'h0, 0, 2'd0);
        repeat (4) add(4'h4, 4'h0, 0, 0, 1, 4'h4, 1, 2'd2);
        add(4'h4, 4'h0, 0, 0, 0, 4'h0, 0, 2'd2);
        repeat (2) add(4'h4, 4'h0, 0, 0, 1, 4'h4, 1, 2'd2);
        repeat (8) add(4'h0, 4'h0, 0, 0, 0, 4'h4, 1, 2'd2);
        add(4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 2'd2);
        // Half-full: each grant limited to one beat, alternating 0 and 1.
        add(4'h3, 4'h0, 0, 1, 0, 4'h0, 0, 2'd2);
        add(4'h3, 4'h0, 0, 1, 1, 4'h1, 1, 2'd0);
        add(4'h3, 4'h0, 0, 1, 0, 4'h0, 0, 2'd0);
        add(4'h3, 4'h0, 0, 1, 1, 4'h2, 1, 2'd1);
        add(4'h3, 4'h0, 0, 1, 0, 4'h0, 0, 2'd1);
        add(4'h3, 4'h0, 0, 1, 1, 4'h1, 1, 2'd0);
        add(4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 2'd0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            req_valid     = tbl[i].v;
            req_last      = tbl[i].l;
            fifo_full     = tbl[i].f;
            fifo_halffull = tbl[i].h;
            cyc($sformatf("vec%0d", i), tbl[i].ew, tbl[i].er, tbl[i].eb, tbl[i].eg);
        end

        // Backpressure on requester 1 for 20 cycles never releases the grant.
        do_reset();
        req_data[15:8] = 8'h5C;
        req_valid = 4'h2;
        fifo_full = 1'b1;
        cyc("full.arb", 0, 4'h0, 0, 2'd0);
        for (int i = 0; i < 20; i++) cyc($sformatf("full.hold%0d", i), 0, 4'h0, 1, 2'd1);
        fifo_full = 1'b0;
        cyc("full.resume", 1, 4'h2, 1, 2'd1);
        req_last = 4'h2;
        cyc("full.last", 1, 4'h2, 1, 2'd1);
        req_valid = 4'h0;
        req_last  = 4'h0;
        cyc("full.done", 0, 4'h0, 0, 2'd1);

        // Requester 3 goes quiet: release on the 8th stall cycle, then 0 wins.
        do_reset();
        req_valid = 4'h8;
        cyc("st.arb", 0, 4'h0, 0, 2'd0);
        cyc("st.beat", 1, 4'h8, 1, 2'd3);
        req_valid = 4'h1;
        for (int i = 0; i < 8; i++) cyc($sformatf("st.stall%0d", i), 0, 4'h8, 1, 2'd3);
        cyc("st.rel", 0, 4'h0, 0, 2'd3);
        cyc("st.next", 1, 4'h1, 1, 2'd0);

        // Reset on beat 2 of a burst aborts it; requester 0 wins next.
        do_reset();
        req_valid = 4'h4;
        cyc("rst.arb", 0, 4'h0, 0, 2'd0);
        cyc("rst.beat1", 1, 4'h4, 1, 2'd2);
        wrst = 1'b1;
        cyc("rst.beat2", 1, 4'h4, 1, 2'd2);
        wrst      = 1'b0;
        req_valid = 4'h5;
        idle_outputs("rst.after");
        cyc("rst.regrant", 1, 4'h1, 1, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
